// File: rtl/calc_ctrl_pkg.sv
// Shared constants and state encoding for the calculator control FSM.
package calc_ctrl_pkg;

  localparam int unsigned KEY_LEN = 4;
  localparam logic [KEY_LEN-1:0] KEY = 4'b1010;  // first bit received is KEY[3]

  typedef enum logic [3:0] {
    StIdle,
    StK1,
    StK10,
    StK101,
    StMode,
    StSample,
    StMem,
    StTx,
    StDone
  } state_t;

endpackage

// File: rtl/calc_controller.sv
// Main calculator control FSM: serial key unlock, mode latch, and sequencing of
// sample / memory / transmit strobes. Outputs are decoded from the state register.
module calc_controller
  import calc_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inputKey,
  input  logic validCmd,
  input  logic RW,
  input  logic txDone,
  output logic active,
  output logic mode,
  output logic AccessMem,
  output logic RWMem,
  output logic SampleData,
  output logic TxData,
  output logic Busy
);

  state_t state_q;
  logic   mode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:   state_q <= (validCmd && inputKey == KEY[3]) ? StK1 : StIdle;
        // A mismatching key bit is discarded; no overlap reuse.
        StK1:     state_q <= (validCmd && inputKey == KEY[2]) ? StK10 : StIdle;
        StK10:    state_q <= (validCmd && inputKey == KEY[1]) ? StK101 : StIdle;
        StK101:   state_q <= (validCmd && inputKey == KEY[0]) ? StMode : StIdle;
        StMode: begin
          if (validCmd) begin
            mode_q  <= inputKey;
            state_q <= StSample;
          end else begin
            state_q <= StIdle;
          end
        end
        StSample: state_q <= mode_q ? StMem : StTx;
        StMem:    state_q <= RW ? StDone : StTx;
        StTx:     state_q <= txDone ? StDone : StTx;
        StDone:   state_q <= validCmd ? StDone : StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    active     = 1'b0;
    AccessMem  = 1'b0;
    RWMem      = 1'b0;
    SampleData = 1'b0;
    TxData     = 1'b0;
    Busy       = 1'b0;
    unique case (state_q)
      StSample: begin
        active     = 1'b1;
        SampleData = 1'b1;
        Busy       = 1'b1;
      end
      StMem: begin
        active    = 1'b1;
        AccessMem = 1'b1;
        RWMem     = RW;
        Busy      = 1'b1;
      end
      StTx: begin
        active = 1'b1;
        TxData = 1'b1;
        Busy   = 1'b1;
      end
      StDone:  active = 1'b1;
      default: ;
    endcase
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: vector table plus reset corner cases.
module tb_calc_controller;

  logic clk, reset, inputKey, validCmd, RW, txDone;
  logic active, mode, AccessMem, RWMem, SampleData, TxData, Busy;

  calc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .inputKey  (inputKey),
    .validCmd  (validCmd),
    .RW        (RW),
    .txDone    (txDone),
    .active    (active),
    .mode      (mode),
    .AccessMem (AccessMem),
    .RWMem     (RWMem),
    .SampleData(SampleData),
    .TxData    (TxData),
    .Busy      (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {active, mode, AccessMem, RWMem, SampleData, TxData, Busy}
  logic [6:0] outs;
  assign outs = {active, mode, AccessMem, RWMem, SampleData, TxData, Busy};

  typedef struct packed {
    logic       v;
    logic       k;
    logic       rw;
    logic       td;
    logic [6:0] exp;
  } vec_t;

  localparam int NVEC = 39;
  vec_t vecs [NVEC];

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, req);
  endtask

  task automatic step(input logic v, input logic k, input logic rw, input logic td);
    validCmd = v;
    inputKey = k;
    RW       = rw;
    txDone   = td;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Mode 1 read: key, mode=1, SAMPLE, MEM, TX, DONE, IDLE
    vecs[0]  = '{1, 1, 0, 0, 7'b0000000};
    vecs[1]  = '{1, 0, 0, 0, 7'b0000000};
    vecs[2]  = '{1, 1, 0, 0, 7'b0000000};
    vecs[3]  = '{1, 0, 0, 0, 7'b0000000};
    vecs[4]  = '{1, 1, 0, 0, 7'b1100101};
    vecs[5]  = '{1, 0, 0, 0, 7'b1110001};
    vecs[6]  = '{1, 0, 0, 0, 7'b1100011};
    vecs[7]  = '{0, 0, 0, 0, 7'b1100011};
    vecs[8]  = '{0, 0, 0, 1, 7'b1100000};
    vecs[9]  = '{0, 0, 0, 0, 7'b0100000};
    // Mode 0: SAMPLE then TX directly; DONE holds while validCmd
    vecs[10] = '{1, 1, 0, 0, 7'b0100000};
    vecs[11] = '{1, 0, 0, 0, 7'b0100000};
    vecs[12] = '{1, 1, 0, 0, 7'b0100000};
    vecs[13] = '{1, 0, 0, 0, 7'b0100000};
    vecs[14] = '{1, 0, 1, 0, 7'b1000101};
    vecs[15] = '{1, 0, 1, 0, 7'b1000011};
    vecs[16] = '{1, 0, 1, 1, 7'b1000000};
    vecs[17] = '{1, 0, 0, 0, 7'b1000000};
    vecs[18] = '{0, 0, 0, 0, 7'b0000000};
    // Wrong key 1,0,0,1,0 never unlocks; txDone in IDLE ignored
    vecs[19] = '{1, 1, 0, 0, 7'b0000000};
    vecs[20] = '{1, 0, 0, 0, 7'b0000000};
    vecs[21] = '{1, 0, 0, 0, 7'b0000000};
    vecs[22] = '{1, 1, 0, 0, 7'b0000000};
    vecs[23] = '{1, 0, 0, 0, 7'b0000000};
    vecs[24] = '{0, 0, 0, 0, 7'b0000000};
    vecs[25] = '{0, 0, 0, 1, 7'b0000000};
    // Mode 1 write: MEM with RWMem=1 then DONE, no TX
    vecs[26] = '{1, 1, 0, 0, 7'b0000000};
    vecs[27] = '{1, 0, 0, 0, 7'b0000000};
    vecs[28] = '{1, 1, 0, 0, 7'b0000000};
    vecs[29] = '{1, 0, 0, 0, 7'b0000000};
    vecs[30] = '{1, 1, 1, 0, 7'b1100101};
    vecs[31] = '{1, 0, 1, 0, 7'b1111001};
    vecs[32] = '{1, 0, 1, 0, 7'b1100000};
    vecs[33] = '{0, 0, 0, 0, 7'b0100000};
    // validCmd drop during key entry aborts back to IDLE
    vecs[34] = '{1, 1, 0, 0, 7'b0100000};
    vecs[35] = '{1, 0, 0, 0, 7'b0100000};
    vecs[36] = '{1, 1, 0, 0, 7'b0100000};
    vecs[37] = '{0, 0, 0, 0, 7'b0100000};
    vecs[38] = '{1, 1, 0, 0, 7'b0100000};

    reset    = 1'b1;
    validCmd = 1'b0;
    inputKey = 1'b0;
    RW       = 1'b0;
    txDone   = 1'b0;
    #8;
    check("reset_outputs", outs, 7'b0000000);
    #5;
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].v, vecs[i].k, vecs[i].rw, vecs[i].td);
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
      @(negedge clk);
    end

    // After vec38 the FSM is in K1; a drop in MODE must also abort.
    step(1, 0, 0, 0);
    @(negedge clk);
    step(1, 1, 0, 0);
    @(negedge clk);
    step(1, 0, 0, 0);
    @(negedge clk);
    step(0, 1, 0, 0);
    check("mode_abort_idle", outs, 7'b0100000);
    @(negedge clk);

    // Reset asserted mid-TX clears everything without waiting for a clock.
    step(1, 1, 0, 0);
    @(negedge clk);
    step(1, 0, 0, 0);
    @(negedge clk);
    step(1, 1, 0, 0);
    @(negedge clk);
    step(1, 0, 0, 0);
    @(negedge clk);
    step(1, 1, 0, 0);
    @(negedge clk);
    begin
      int cyc = 0;
      while (!TxData && cyc < 8) begin
        step(1, 1, 0, 0);
        @(negedge clk);
        cyc++;
      end
      check("reach_tx", {6'b0, TxData}, 7'b0000001);
    end
    check("tx_outputs", outs, 7'b1100011);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_tx", outs, 7'b0000000);
    @(posedge clk);
    #1;
    check("reset_held", outs, 7'b0000000);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 1);
    check("post_reset_idle", outs, 7'b0000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
